rpi_irq_clk_gen: RTL and testbench

Multi-channel, parametrised interrupt-clock generator driving Raspberry Pi GPIO interrupt lines from the FPGA fabric. Each channel turns a rising edge on its request line into a registered square wave on its own output. The wave has a programmable half-period and runs either continuously or as a fixed-length burst. A Pi-side acknowledge line stops it early. It sits between the audio/I2S control logic (request side) and the Pi GPIO pins (output/ack side), all on the 50 MHz codec clock.

---
 rtl/rpi_irq_pkg.sv | 15 +
 rtl/rpi_irq_clk_gen_if.sv | 28 ++
 rtl/rpi_irq_chan.sv | 122 ++++++++++++
 rtl/rpi_irq_clk_gen.sv | 39 +++
 tb/tb_rpi_irq_clk_gen.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/rpi_irq_pkg.sv
// Shared types and default sizing for the Raspberry Pi interrupt-clock generator.
package rpi_irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } chan_state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/rpi_irq_clk_gen_if.sv
// Request/config side and Pi GPIO side of the interrupt-clock generator.
interface rpi_irq_clk_gen_if
    import rpi_irq_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int CNT_W    = DEF_CNT_W
);

    logic [DIV_W-1:0]    half_period;
    logic [CNT_W-1:0]    burst_len;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] irq_ack;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;

    modport master (
        output half_period, burst_len, irq_en, irq_ack,
        input  clk_out, busy, done
    );

    modport slave (
        input  half_period, burst_len, irq_en, irq_ack,
        output clk_out, busy, done
    );

endinterface

// File: rtl/rpi_irq_chan.sv
// One interrupt-clock channel: start-edge detect, ack synchroniser, FSM and counters.
//   state | meaning
//   IDLE  | waiting for a rising edge on irq_en, clk_out=0
//   HIGH  | high phase of a period, clk_out=1
//   LOW   | low phase of a period, clk_out=0
//   DONE  | burst finished, done=1 until the Pi acknowledges
module rpi_irq_chan
    import rpi_irq_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] half_period,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             irq_en,
    input  logic             irq_ack,
    output logic             clk_out,
    output logic             busy,
    output logic             done
);

    localparam logic [DIV_W-1:0] PHASE_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] PULSE_ONE = CNT_W'(1);

    chan_state_t      state, state_nxt;
    logic [DIV_W-1:0] phase_cnt, phase_nxt;
    logic [DIV_W-1:0] h_lat, h_nxt;
    logic [CNT_W-1:0] pulse_cnt, pulse_nxt;
    logic [CNT_W-1:0] b_lat, b_nxt;
    logic             en_prev;
    logic             ack_meta;
    logic             ack_s;
    logic             start;
    logic             phase_end;

    assign start     = irq_en & ~en_prev;
    assign phase_end = (phase_cnt == PHASE_ONE);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            pulse_cnt <= '0;
            h_lat     <= '0;
            b_lat     <= '0;
            en_prev   <= 1'b0;
            ack_meta  <= 1'b0;
            ack_s     <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            pulse_cnt <= pulse_nxt;
            h_lat     <= h_nxt;
            b_lat     <= b_nxt;
            en_prev   <= irq_en;
            ack_meta  <= irq_ack;
            ack_s     <= ack_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        pulse_nxt = pulse_cnt;
        h_nxt     = h_lat;
        b_nxt     = b_lat;
        unique case (state)
            IDLE: begin
                // a synchronised ack in the same cycle suppresses the start
                if (start && !ack_s) begin
                    state_nxt = HIGH;
                    h_nxt     = (half_period == '0) ? PHASE_ONE : half_period;
                    b_nxt     = burst_len;
                    phase_nxt = h_nxt;
                    pulse_nxt = PULSE_ONE;
                end
            end
            HIGH: begin
                if (ack_s) begin
                    state_nxt = IDLE;
                end else if (phase_end) begin
                    state_nxt = LOW;
                    phase_nxt = h_lat;
                end else begin
                    phase_nxt = phase_cnt - PHASE_ONE;
                end
            end
            LOW: begin
                if (ack_s) begin
                    state_nxt = IDLE;
                end else if (phase_end) begin
                    phase_nxt = h_lat;
                    if (b_lat == '0) begin
                        state_nxt = irq_en ? HIGH : IDLE;
                    end else if (pulse_cnt < b_lat) begin
                        state_nxt = HIGH;
                        pulse_nxt = pulse_cnt + PULSE_ONE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    phase_nxt = phase_cnt - PHASE_ONE;
                end
            end
            DONE: begin
                if (ack_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clk_out = (state == HIGH);
        busy    = (state == HIGH) || (state == LOW);
        done    = (state == DONE);
    end

endmodule

// File: rtl/rpi_irq_clk_gen.sv
// Multi-channel interrupt-clock generator; config inputs fan out, each channel latches its own copy.
module rpi_irq_clk_gen
    import rpi_irq_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk_in,
    input  logic               rst_n,
    rpi_irq_clk_gen_if.slave   bus
);

    logic [CHANNELS-1:0] clk_out_w;
    logic [CHANNELS-1:0] busy_w;
    logic [CHANNELS-1:0] done_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        rpi_irq_chan #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .half_period (bus.half_period),
            .burst_len   (bus.burst_len),
            .irq_en      (bus.irq_en[i]),
            .irq_ack     (bus.irq_ack[i]),
            .clk_out     (clk_out_w[i]),
            .busy        (busy_w[i]),
            .done        (done_w[i])
        );
    end

    assign bus.clk_out = clk_out_w;
    assign bus.busy    = busy_w;
    assign bus.done    = done_w;

endmodule

// File: tb/tb_rpi_irq_clk_gen.sv
// Scoreboard bench: per-cycle expected waveforms are queued at drive time and checked after each edge.
module tb_rpi_irq_clk_gen;

    localparam int CH = 4;

    logic clk_in = 1'b0;
    logic rst_n;

    always #5 clk_in = ~clk_in;

    rpi_irq_clk_gen_if #(.CHANNELS(CH), .DIV_W(8), .CNT_W(8)) bus ();

    rpi_irq_clk_gen #(.CHANNELS(CH), .DIV_W(8), .CNT_W(8)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // per-channel stimulus/expectation strings, one char per cycle
    // exp chars: '0' idle, '1' high, 'l' low, 'D' done
    string      en_tbl[CH];
    string      ack_tbl[CH];
    string      exp_tbl[CH];
    string      rst_tbl;
    logic [7:0] hp_a, hp_b, bl_a, bl_b;
    int         sw_cyc;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {clk_out,busy,done}=%03h, expected %03h", tag, got, exp);
        end
    endtask

    function automatic logic tbl_bit(input string s, input int n);
        byte c;
        c = (n < s.len()) ? s[n] : "0";
        return (c == "1");
    endfunction

    function automatic logic [2:0] wave_bits(input string s, input int n);
        byte c;
        c = (n < s.len()) ? s[n] : "0";
        case (c)
            "1":     return 3'b110;
            "l":     return 3'b010;
            "D":     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic clear_tbl();
        for (int i = 0; i < CH; i++) begin
            en_tbl[i]  = "";
            ack_tbl[i] = "";
            exp_tbl[i] = "";
        end
        rst_tbl = "";
        sw_cyc  = 1000;
    endtask

    task automatic run_seq(input string tag, input int len);
        for (int n = 0; n < len; n++) begin
            sb_t        e;
            logic [3:0] co, bz, dn;
            @(negedge clk_in);
            rst_n           = !tbl_bit(rst_tbl, n);
            bus.half_period = (n < sw_cyc) ? hp_a : hp_b;
            bus.burst_len   = (n < sw_cyc) ? bl_a : bl_b;
            for (int i = 0; i < CH; i++) begin
                bus.irq_en[i]  = tbl_bit(en_tbl[i], n);
                bus.irq_ack[i] = tbl_bit(ack_tbl[i], n);
                {co[i], bz[i], dn[i]} = wave_bits(exp_tbl[i], n);
            end
            e.tag = $sformatf("%s[%0d]", tag, n);
            e.exp = {co, bz, dn};
            sb_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (sb_q.size() > 0) begin
                sb_t e;
                e = sb_q.pop_front();
                chk(e.tag, {bus.clk_out, bus.busy, bus.done}, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.irq_en      = '0;
        bus.irq_ack     = '0;
        bus.half_period = '0;
        bus.burst_len   = '0;

        clear_tbl();
        hp_a = 8'd3; bl_a = 8'd0; hp_b = hp_a; bl_b = bl_a;
        rst_tbl = "111";
        run_seq("reset", 4);

        // burst H=3 B=2, ack from DONE, level held high never restarts
        clear_tbl();
        hp_a = 8'd3; bl_a = 8'd2;
        en_tbl[0]  = {"0", "1111111111", "1111111111", "11"};
        ack_tbl[0] = {"0000000000", "000000", "1", "000000"};
        exp_tbl[0] = {"0", "111", "lll", "111", "lll", "DDDDD", "00000"};
        run_seq("burst", 23);

        // continuous H=2, enable high 5 cycles: two full periods then idle
        clear_tbl();
        hp_a = 8'd2; bl_a = 8'd0;
        en_tbl[0]  = "0111110000000";
        exp_tbl[0] = "011ll11ll0000";
        run_seq("cont_stop", 13);

        // abort mid first HIGH
        clear_tbl();
        hp_a = 8'd4; bl_a = 8'd10;
        en_tbl[0]  = "0111111111";
        ack_tbl[0] = "0010000000";
        exp_tbl[0] = "0111000000";
        run_seq("abort", 10);

        // half_period=0 behaves as 1
        clear_tbl();
        hp_a = 8'd0; bl_a = 8'd0;
        en_tbl[0]  = "011110000";
        exp_tbl[0] = "01l1l0000";
        run_seq("hp_zero", 9);

        // start coincident with synchronised ack stays idle
        clear_tbl();
        hp_a = 8'd3; bl_a = 8'd0;
        en_tbl[0]  = "000111111";
        ack_tbl[0] = "010000000";
        exp_tbl[0] = "000000000";
        run_seq("start_ack", 9);

        // independence: ch1 burst H=1 B=3, then config changes and ch2 runs continuous H=5
        clear_tbl();
        hp_a = 8'd1; bl_a = 8'd3; hp_b = 8'd5; bl_b = 8'd0; sw_cyc = 2;
        en_tbl[1]  = {"0", "1111111111", "1111111111", "11111"};
        ack_tbl[1] = {"0000000000", "0000000000", "1", "00000"};
        exp_tbl[1] = {"01l1l1l", "DDDDDDDDDDDDDDD", "0000"};
        en_tbl[2]  = {"000", "11111111111", "000000000000"};
        exp_tbl[2] = {"000", "11111", "lllll", "11111", "lllll", "000"};
        run_seq("indep", 26);

        // reset mid-HIGH, enable still high gives a clean restart
        clear_tbl();
        hp_a = 8'd4; bl_a = 8'd2; hp_b = hp_a; bl_b = bl_a;
        rst_tbl    = "0001";
        en_tbl[0]  = {"0", "1111111111", "1111111111", "1"};
        exp_tbl[0] = {"0110", "1111", "llll", "1111", "llll", "DD"};
        run_seq("rst_mid", 22);

        repeat (3) @(posedge clk_in);
        #2;
        chk("sb_drain", 12'(sb_q.size()), 12'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
